// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART constants: FSM encoding, oversample ratio, parity modes and the 9600-baud divider step.
// Imported by the tx serializer today and intended for the divider and the rx path as well.
package uart_tx_serializer_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [1:0] PARITY_MODE_NONE = 2'd0;
    localparam logic [1:0] PARITY_MODE_EVEN = 2'd1;
    localparam logic [1:0] PARITY_MODE_ODD  = 2'd2;

    // Phase-accumulator step: 2^32 * 9600 * 16 / 100 MHz.
    localparam logic [31:0] DEVIDE_CNT = 32'd6597070;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Upstream valid/ready word interface feeding the UART transmitter.
interface uart_tx_serializer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer_bit_timer.sv
// Counts oversample ticks and pulses bit_end on the tick that closes a bit period.
// Held at zero while clear is high so the first bit always gets its full tick count.
module uart_bit_timer #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic baud_x16_en,
    output logic bit_end
);
    localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_end    = 1'b0;
        if (clear) begin
            tick_cnt_d = '0;
        end else if (baud_x16_en) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
                bit_end    = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tick_cnt_q <= '0;
        else     tick_cnt_q <= tick_cnt_d;
    end
endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s).
// Driven by a 16x oversample enable from the baud divider; txd is a registered output.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_x16_en,
    uart_tx_serializer_if.slave  tx,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 txd_q, txd_d;
    logic                 done_q, done_d;
    logic                 bit_end;
    logic                 idle;
    logic                 accept;
    logic                 par;

    assign idle        = (state_q == ST_IDLE);
    assign accept      = idle & tx.tx_valid;
    assign tx.tx_ready = idle;
    assign par         = parity_bit(8'(data_q), (PARITY_ODD != 0));

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (idle),
        .baud_x16_en (baud_x16_en),
        .bit_end     (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d   = tx.tx_data;
                    data_d    = tx.tx_data;
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level is decoded from the next state so txd lines up with state_q.
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = par;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
        end
    end

    assign txd     = txd_q;
    assign tx_busy = ~idle;
    assign tx_done = done_q;
endmodule
